// File: rtl/led4_pipe_checker.sv
// Purpose     : verifies a 4-bit running-light bus (one-hot, rotating left) and reports lock, position, faults, laps.
// Latency     : one register stage; outputs reflect the diode value present before the edge, right after that edge.
// Backpressure: none; the checker observes the bus every cycle and never stalls the generator.
//
// Ports:
//   clock      - single clock, all state updates on the rising edge
//   reset      - synchronous active-high reset
//   diode      - observed running-light bus, synchronous to clock
//   locked     - high while the observed sequence is verified correct
//   pos        - index of the lit LED while locked, 0 otherwise
//   err_pulse  - one-cycle pulse per detected fault
//   err_count  - faults since reset, saturating at 255
//   lap_count  - completed rotations while locked, wraps 255->0
module led4_pipe_checker #(
   parameter int unsigned LOCK_STEPS = 4,    // consecutive legal steps required to lock (1..15)
   parameter int unsigned TIMEOUT    = 255   // max cycles without a step while locked (2..65535)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] diode,
   output logic       locked,
   output logic [1:0] pos,
   output logic       err_pulse,
   output logic [7:0] err_count,
   output logic [7:0] lap_count
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0]  LOCK_STEPS_W = 4'(LOCK_STEPS);
   localparam logic [15:0] TIMEOUT_W    = 16'(TIMEOUT);

   // Registered state
   state_t      state_q;
   logic [3:0]  d_q;        // diode value sampled on the previous edge
   logic [3:0]  step_q;     // legal steps seen while in SYNC
   logic [15:0] stall_q;    // cycles since the last step while in LOCKED

   // Next-state values
   state_t      state_d;
   logic [3:0]  step_d;
   logic [15:0] stall_d;
   logic        locked_d;
   logic [1:0]  pos_d;
   logic        err_d;
   logic [7:0]  err_count_d;
   logic [7:0]  lap_count_d;

   // Event classification of the current diode against d_q
   logic        ev_hold;
   logic        ev_step;
   logic        ev_bad;
   logic [3:0]  d_rot;
   logic [15:0] stall_inc;
   logic        timeout_hit;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   function automatic logic [1:0] bit_index(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   assign d_rot   = {d_q[2:0], d_q[3]};
   assign ev_hold = (diode == d_q);
   // A step must land on a legal (one-hot) pattern; a hold is never a step.
   assign ev_step = !ev_hold && is_onehot(diode) && (diode == d_rot);
   assign ev_bad  = !ev_hold && !ev_step;

   // The stall counter saturates rather than wrapping; in practice the
   // timeout fault fires long before saturation is reachable.
   assign stall_inc   = (stall_q == 16'hFFFF) ? stall_q : (stall_q + 16'd1);
   assign timeout_hit = ev_hold && (stall_inc == TIMEOUT_W);

   // State register and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= HUNT;
         d_q       <= 4'b0000;
         step_q    <= 4'd0;
         stall_q   <= 16'd0;
         locked    <= 1'b0;
         pos       <= 2'd0;
         err_pulse <= 1'b0;
         err_count <= 8'd0;
         lap_count <= 8'd0;
      end else begin
         state_q   <= state_d;
         d_q       <= diode;
         step_q    <= step_d;
         stall_q   <= stall_d;
         locked    <= locked_d;
         pos       <= pos_d;
         err_pulse <= err_d;
         err_count <= err_count_d;
         lap_count <= lap_count_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      stall_d     = 16'd0;
      locked_d    = 1'b0;
      pos_d       = 2'd0;
      err_d       = 1'b0;
      err_count_d = err_count;
      lap_count_d = lap_count;

      case (state_q)
         HUNT: begin
            // Any one-hot value is a candidate starting point; nothing here is a fault.
            step_d = 4'd0;
            if (is_onehot(diode)) begin
               state_d = SYNC;
            end
         end

         SYNC: begin
            if (ev_step) begin
               if ((step_q + 4'd1) == LOCK_STEPS_W) begin
                  state_d  = LOCKED;
                  step_d   = 4'd0;
                  locked_d = 1'b1;
                  pos_d    = bit_index(diode);
               end else begin
                  step_d = step_q + 4'd1;
               end
            end else if (ev_bad) begin
               // Not yet trusted, so a bad move simply restarts the hunt.
               state_d = HUNT;
               step_d  = 4'd0;
            end
         end

         LOCKED: begin
            if (ev_bad || timeout_hit) begin
               // BAD and timeout are merged into a single fault.
               state_d     = HUNT;
               err_d       = 1'b1;
               err_count_d = (err_count == 8'hFF) ? err_count : (err_count + 8'd1);
            end else if (ev_step) begin
               locked_d = 1'b1;
               pos_d    = bit_index(diode);
               if (diode == 4'b0001) begin
                  lap_count_d = lap_count + 8'd1;
               end
            end else begin
               locked_d = 1'b1;
               pos_d    = pos;
               stall_d  = stall_inc;
            end
         end

         default: begin
            state_d = HUNT;
            step_d  = 4'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_led4_pipe_checker.sv
module tb_led4_pipe_checker;

   logic       clock;
   logic       reset;
   logic [3:0] diode;
   logic       locked;
   logic [1:0] pos;
   logic       err_pulse;
   logic [7:0] err_count;
   logic [7:0] lap_count;

   int checks;
   int failures;

   led4_pipe_checker #(
      .LOCK_STEPS (4),
      .TIMEOUT    (255)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .diode     (diode),
      .locked    (locked),
      .pos       (pos),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .lap_count (lap_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Watchdog: the bench is fixed-length, this only guards against a stuck simulator.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] d;
      logic       lk;
      logic [1:0] p;
      logic       e;
      logic [7:0] ec;
      logic [7:0] lp;
   } vec_t;

   vec_t tbl [26];

   // Drive diode, take one rising edge, settle 1 time unit past it.
   task automatic tick(input logic [3:0] d);
      diode = d;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic lk, input logic [1:0] p,
                          input logic e, input logic [7:0] ec, input logic [7:0] lp);
      chk({tag, ".locked"},    32'(locked),    32'(lk));
      chk({tag, ".pos"},       32'(pos),       32'(p));
      chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(e));
      chk({tag, ".err_count"}, 32'(err_count), 32'(ec));
      chk({tag, ".lap_count"}, 32'(lap_count), 32'(lp));
   endtask

   initial begin
      logic [3:0] v;
      logic       exp_lk;
      logic [1:0] exp_p;
      logic [7:0] exp_ec;

      checks   = 0;
      failures = 0;

      //               diode    lk    pos   err   ecnt  lap
      tbl[0]  = '{4'b0001, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0};  // HUNT -> SYNC
      tbl[1]  = '{4'b0010, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0};  // step 1
      tbl[2]  = '{4'b0100, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0};  // step 2
      tbl[3]  = '{4'b1000, 1'b0, 2'd0, 1'b0, 8'd0, 8'd0};  // step 3
      tbl[4]  = '{4'b0001, 1'b1, 2'd0, 1'b0, 8'd0, 8'd0};  // step 4: lock, no lap
      tbl[5]  = '{4'b0010, 1'b1, 2'd1, 1'b0, 8'd0, 8'd0};
      tbl[6]  = '{4'b0100, 1'b1, 2'd2, 1'b0, 8'd0, 8'd0};
      tbl[7]  = '{4'b1000, 1'b1, 2'd3, 1'b0, 8'd0, 8'd0};
      tbl[8]  = '{4'b0001, 1'b1, 2'd0, 1'b0, 8'd0, 8'd1};  // lap
      tbl[9]  = '{4'b0001, 1'b1, 2'd0, 1'b0, 8'd0, 8'd1};  // hold
      tbl[10] = '{4'b0010, 1'b1, 2'd1, 1'b0, 8'd0, 8'd1};
      tbl[11] = '{4'b0110, 1'b0, 2'd0, 1'b1, 8'd1, 8'd1};  // non-one-hot fault
      tbl[12] = '{4'b0100, 1'b0, 2'd0, 1'b0, 8'd1, 8'd1};  // pulse gone, HUNT -> SYNC
      tbl[13] = '{4'b0100, 1'b0, 2'd0, 1'b0, 8'd1, 8'd1};  // hold in SYNC
      tbl[14] = '{4'b1000, 1'b0, 2'd0, 1'b0, 8'd1, 8'd1};
      tbl[15] = '{4'b0001, 1'b0, 2'd0, 1'b0, 8'd1, 8'd1};
      tbl[16] = '{4'b0010, 1'b0, 2'd0, 1'b0, 8'd1, 8'd1};
      tbl[17] = '{4'b0100, 1'b1, 2'd2, 1'b0, 8'd1, 8'd1};  // relock after 4 steps
      tbl[18] = '{4'b1000, 1'b1, 2'd3, 1'b0, 8'd1, 8'd1};
      tbl[19] = '{4'b0001, 1'b1, 2'd0, 1'b0, 8'd1, 8'd2};  // lap
      tbl[20] = '{4'b0100, 1'b0, 2'd0, 1'b1, 8'd2, 8'd2};  // skip move fault
      tbl[21] = '{4'b0100, 1'b0, 2'd0, 1'b0, 8'd2, 8'd2};  // HUNT -> SYNC
      tbl[22] = '{4'b1000, 1'b0, 2'd0, 1'b0, 8'd2, 8'd2};  // step 1
      tbl[23] = '{4'b0100, 1'b0, 2'd0, 1'b0, 8'd2, 8'd2};  // reverse in SYNC: HUNT, no fault
      tbl[24] = '{4'b0000, 1'b0, 2'd0, 1'b0, 8'd2, 8'd2};  // stays in HUNT
      tbl[25] = '{4'b0011, 1'b0, 2'd0, 1'b0, 8'd2, 8'd2};  // stays in HUNT

      // Reset state, with a live-looking bus during reset
      reset = 1'b1;
      tick(4'b0001);
      tick(4'b0001);
      chk_all("reset", 1'b0, 2'd0, 1'b0, 8'd0, 8'd0);
      reset = 1'b0;

      // Directed table
      for (int i = 0; i < 26; i++) begin
         tick(tbl[i].d);
         chk_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].p, tbl[i].e, tbl[i].ec, tbl[i].lp);
      end

      // Generator holding each value 3 cycles: lock on the 4th step, one lap, no faults
      for (int k = 0; k < 9; k++) begin
         v      = 4'b0001 << (k % 4);
         exp_lk = (k >= 4);
         exp_p  = exp_lk ? 2'(k % 4) : 2'd0;
         for (int r = 0; r < 3; r++) begin
            tick(v);
            chk_all($sformatf("hold3_k%0d_r%0d", k, r), exp_lk, exp_p, 1'b0, 8'd2,
                    (k >= 8) ? 8'd3 : 8'd2);
         end
      end

      // Stall timeout while locked: freeze at 0100
      tick(4'b0010);
      tick(4'b0100);
      chk_all("to_entry", 1'b1, 2'd2, 1'b0, 8'd2, 8'd3);
      for (int n = 1; n <= 254; n++) begin
         tick(4'b0100);
      end
      chk_all("to_254", 1'b1, 2'd2, 1'b0, 8'd2, 8'd3);
      tick(4'b0100);
      chk_all("to_255", 1'b0, 2'd0, 1'b1, 8'd3, 8'd3);
      tick(4'b0100);
      chk_all("to_after", 1'b0, 2'd0, 1'b0, 8'd3, 8'd3);

      // 300 faults: err_count saturates at 255, lock entries never count as laps
      for (int i = 0; i < 300; i++) begin
         tick(4'b0000);
         tick(4'b0001);
         tick(4'b0010);
         tick(4'b0100);
         tick(4'b1000);
         tick(4'b0001);
         chk($sformatf("sat_lock%0d", i), 32'(locked), 32'd1);
         exp_ec = ((3 + i + 1) > 255) ? 8'd255 : 8'(3 + i + 1);
         tick(4'b0011);
         chk($sformatf("sat_pulse%0d", i), 32'(err_pulse), 32'd1);
         chk($sformatf("sat_cnt%0d", i), 32'(err_count), 32'(exp_ec));
      end
      chk("sat_final", 32'(err_count), 32'd255);
      chk("sat_lap", 32'(lap_count), 32'd3);

      reset = 1'b1;
      tick(4'b0001);
      chk_all("sat_reset", 1'b0, 2'd0, 1'b0, 8'd0, 8'd0);
      reset = 1'b0;

      // Reset during a would-be fault suppresses it
      tick(4'b0001);
      tick(4'b0010);
      tick(4'b0100);
      tick(4'b1000);
      tick(4'b0001);
      chk_all("mid_lock", 1'b1, 2'd0, 1'b0, 8'd0, 8'd0);
      reset = 1'b1;
      tick(4'b0110);
      chk_all("mid_reset", 1'b0, 2'd0, 1'b0, 8'd0, 8'd0);
      reset = 1'b0;

      // First edge after reset: HUNT with d_q cleared
      tick(4'b0010);
      chk_all("post_rst0", 1'b0, 2'd0, 1'b0, 8'd0, 8'd0);
      tick(4'b0100);
      tick(4'b1000);
      tick(4'b0001);
      chk_all("post_rst3", 1'b0, 2'd0, 1'b0, 8'd0, 8'd0);
      tick(4'b0010);
      chk_all("post_rst4", 1'b1, 2'd1, 1'b0, 8'd0, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
